debounce_bank: RTL



---
 rtl/debounce_bank.sv | 122 ++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer: 2-flop synchroniser, stability counter, press/release strobes.
// Define DEBOUNCE_REPEAT_EN to add a per-channel auto-repeat strobe on held buttons.
module debounce_bank #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned STABLE_CNT  = 1000000,
    parameter bit          ACTIVE_LOW  = 1'b0,
    parameter int unsigned RPT_W       = 26,
    parameter int unsigned REPEAT_DLY  = 50000000,
    parameter int unsigned REPEAT_RATE = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn,
    output logic [N_CH-1:0] btn_clean,
    output logic [N_CH-1:0] press,
    // 'release' is a reserved word, hence the prefix
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] rpt,
    output logic            any_press
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CNT - 1);

    if (N_CH < 1) begin : g_bad_nch
        $error("debounce_bank: N_CH must be at least 1");
    end
    if (STABLE_CNT < 2 || longint'(STABLE_CNT) > (longint'(1) << CNT_W) - 1) begin : g_bad_stable
        $error("debounce_bank: STABLE_CNT out of range for CNT_W");
    end
    if (REPEAT_DLY < 1 || longint'(REPEAT_DLY) > (longint'(1) << RPT_W) - 1) begin : g_bad_dly
        $error("debounce_bank: REPEAT_DLY out of range for RPT_W");
    end
    if (REPEAT_RATE < 1 || longint'(REPEAT_RATE) > (longint'(1) << RPT_W) - 1) begin : g_bad_rate
        $error("debounce_bank: REPEAT_RATE out of range for RPT_W");
    end

    logic [N_CH-1:0] press_nxt;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             s0;
        logic             s1;
        logic [CNT_W-1:0] cnt;
        logic             clean_q;
        logic             press_q;
        logic             rel_q;
        logic             flip;

        // btn_clean takes the synchronised level on this edge
        assign flip         = (s1 != clean_q) && (cnt == CntMax);
        assign press_nxt[i] = flip & s1;

        always_ff @(posedge clk) begin
            if (rst) begin
                s0      <= 1'b0;
                s1      <= 1'b0;
                cnt     <= '0;
                clean_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                s0      <= btn[i] ^ ACTIVE_LOW;
                s1      <= s0;
                press_q <= flip & s1;
                rel_q   <= flip & ~s1;
                if (s1 == clean_q) begin
                    cnt <= '0;
                end else if (cnt == CntMax) begin
                    clean_q <= s1;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign btn_clean[i]   = clean_q;
        assign press[i]       = press_q;
        assign btn_release[i] = rel_q;

`ifdef DEBOUNCE_REPEAT_EN
        localparam logic [RPT_W-1:0] DlyMax  = RPT_W'(REPEAT_DLY - 1);
        localparam logic [RPT_W-1:0] RateMax = RPT_W'(REPEAT_RATE - 1);

        logic [RPT_W-1:0] rc;
        logic             in_repeat;
        logic             rpt_q;

        // Clearing on the falling update keeps rpt out of the release cycle
        always_ff @(posedge clk) begin
            if (rst || !clean_q || flip) begin
                rc        <= '0;
                in_repeat <= 1'b0;
                rpt_q     <= 1'b0;
            end else if (!in_repeat && rc == DlyMax) begin
                rc        <= '0;
                in_repeat <= 1'b1;
                rpt_q     <= 1'b1;
            end else if (in_repeat && rc == RateMax) begin
                rc    <= '0;
                rpt_q <= 1'b1;
            end else begin
                rc    <= rc + 1'b1;
                rpt_q <= 1'b0;
            end
        end

        assign rpt[i] = rpt_q;
`else
        assign rpt[i] = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            any_press <= 1'b0;
        end else begin
            any_press <= |press_nxt;
        end
    end

endmodule
